decoder_core_p: RTL
===================

DECODER_CORE_P -- requirements
Module: decoder_core_p

Interface
REQ-001 Parameter IN_W, default 80: input beat width in bits.
REQ-002 Parameter CODE_W, default 4: packed code width; IN_W SHALL be a multiple of CODE_W; CPB = IN_W/CODE_W codes per beat.
REQ-003 Parameter ELEM_W, default 8: decoded element width; ELEM_W >= CODE_W.
REQ-004 Parameter FRAME_ELEMS, default 28: elements per output frame; output width OUT_W = FRAME_ELEMS*ELEM_W (default 224).
REQ-005 Parameter SIGNED, default 1: 1 = sign-extend codes, 0 = zero-extend codes.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 flush  input  1  synchronous discard of buffered codes.
REQ-009 data_in  input  IN_W  packed codes; code j = data_in[j*CODE_W +: CODE_W], j=0 oldest.
REQ-010 valid_in  input  1  data_in valid.
REQ-011 ready_in  output  1  block can accept a beat this cycle.
REQ-012 data_out  output  OUT_W  decoded frame; element e = data_out[e*ELEM_W +: ELEM_W], e=0 oldest.
REQ-013 valid_out  output  1  data_out valid.
REQ-014 ready_out  input  1  downstream accepts frame.

Function
REQ-015 Beat accepted when valid_in && ready_in at a rising edge; frame consumed when valid_out && ready_out.
REQ-016 Internal code buffer SHALL hold CAP = FRAME_ELEMS + CPB - 1 codes, count register cnt in [0, CAP].
REQ-017 ready_in SHALL equal (cnt <= CAP - CPB) && !flush, derived from registered state only.
REQ-018 Two states: FILL (valid_out=0) and HOLD (valid_out=1); FILL->HOLD on load, HOLD->FILL on consume with no reload, HOLD->HOLD on consume with reload.
REQ-019 Load occurs when cnt >= FRAME_ELEMS and (state FILL or consume this cycle): oldest FRAME_ELEMS codes decoded into data_out, buffer shifted down, cnt reduced by FRAME_ELEMS.
REQ-020 Accepted beat appended above remaining codes in the same edge as a load; cnt_next = cnt - (load?FRAME_ELEMS:0) + (accept?CPB:0).
REQ-021 Minimum latency: frame completed by a beat accepted at edge k SHALL show valid_out=1 after edge k+1.
REQ-022 data_out and valid_out SHALL hold stable while valid_out && !ready_out.
REQ-023 Decode: SIGNED=1 replicates code MSB into upper ELEM_W-CODE_W bits; SIGNED=0 fills zeros.
REQ-024 flush SHALL set cnt=0 and discard buffered codes, block acceptance that cycle, and leave a held frame (valid_out) untouched.
REQ-025 Codes SHALL straddle frames with no loss or reordering when FRAME_ELEMS is not a multiple of CPB.

Reset
REQ-026 rst asserted SHALL immediately force cnt=0, state FILL, valid_out=0, data_out=0; ready_in=1 after release.
REQ-027 rst mid-frame SHALL discard partial and held frames; first frame after release starts at next accepted beat's code 0.

Configuration
REQ-028 Macro DECODER_CORE_P_STATS_EN defined: adds output frame_cnt (16 bits), reset to 0 by rst only, incremented on each consume, wrapping 0xFFFF->0x0000.
REQ-029 Macro undefined: no frame_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-030 Defaults, beats B0,B1 back-to-back, ready_out=1 -> cnt 20 then 40, ready_in=0 at cnt=40, one frame = B0 codes 0-19 + B1 codes 0-7, cnt=12 after load.
REQ-031 Defaults, 7 beats continuous, ready_out=1 -> exactly 5 frames (140 codes), cnt=0 at end, codes in order.
REQ-032 SIGNED=1 code 4'h8 -> element 8'hF8; SIGNED=0 code 4'h8 -> 8'h08; code 4'h7 -> 8'h07 both.
REQ-033 ready_out=0 for 10 cycles with frame held -> data_out/valid_out stable, ready_in=0 once cnt>27, no code lost after ready_out=1.
REQ-034 flush with cnt=12 and frame held -> cnt=0, held frame still delivered, next frame starts at next beat code 0.
REQ-035 rst asserted mid-stream asynchronously -> valid_out=0 before next clock edge; with STATS_EN frame_cnt=0.

Source files
------------

// File: rtl/decoder_core_p.sv
// Unpacks CODE_W-bit codes from IN_W-bit beats and emits FRAME_ELEMS sign- or zero-extended elements per frame.
// Optional DECODER_CORE_P_STATS_EN adds a 16-bit wrapping count of consumed frames (frame_cnt).
module decoder_core_p #(
  parameter int IN_W        = 80,
  parameter int CODE_W      = 4,
  parameter int ELEM_W      = 8,
  parameter int FRAME_ELEMS = 28,
  parameter int SIGNED      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [IN_W-1:0]               data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic [FRAME_ELEMS*ELEM_W-1:0] data_out,
  output logic                          valid_out,
  input  logic                          ready_out
`ifdef DECODER_CORE_P_STATS_EN
  ,
  output logic [15:0]                   frame_cnt
`endif
);

  // Handshake: a beat moves on a rising edge with valid_in && ready_in, a frame with valid_out && ready_out;
  // valid_out and data_out never change while a frame waits for ready_out.
  localparam int CPB   = IN_W / CODE_W;
  localparam int CAP   = FRAME_ELEMS + CPB - 1;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int BUF_W = CAP * CODE_W;
  localparam int OUT_W = FRAME_ELEMS * ELEM_W;

  localparam logic [CNT_W-1:0] FE_C      = CNT_W'(FRAME_ELEMS);
  localparam logic [CNT_W-1:0] CPB_C     = CNT_W'(CPB);
  localparam logic [CNT_W-1:0] ACC_MAX_C = CNT_W'(CAP - CPB);

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, base;
  logic [BUF_W-1:0]  code_buf, buf_next, shifted, beat_ext;
  logic [OUT_W-1:0]  frame_next;
  logic              accept, consume, load;

  assign ready_in  = (cnt <= ACC_MAX_C) && !flush;
  assign valid_out = (state == HOLD);
  assign accept    = valid_in && ready_in;
  assign consume   = valid_out && ready_out;
  // A flush discards the buffer, so it must not also feed a new frame.
  assign load      = (cnt >= FE_C) && ((state == FILL) || consume) && !flush;

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (load) state_next = HOLD;
      HOLD:    if (consume && !load) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Slots at or above cnt are kept zero, so a new beat can be OR-ed in above the survivors.
  always_comb begin
    shifted  = load ? (code_buf >> (FRAME_ELEMS * CODE_W)) : code_buf;
    base     = load ? (cnt - FE_C) : cnt;
    beat_ext = {{(BUF_W - IN_W){1'b0}}, data_in};
    buf_next = accept ? (shifted | (beat_ext << (32'(base) * CODE_W))) : shifted;
    cnt_next = accept ? (base + CPB_C) : base;
    if (flush) begin
      buf_next = '0;
      cnt_next = '0;
    end
  end

  always_comb begin
    frame_next = '0;
    for (int e = 0; e < FRAME_ELEMS; e++) begin
      for (int b = 0; b < ELEM_W; b++) begin
        if (b < CODE_W)
          frame_next[e*ELEM_W + b] = code_buf[e*CODE_W + b];
        else
          frame_next[e*ELEM_W + b] = (SIGNED != 0) ? code_buf[e*CODE_W + CODE_W - 1] : 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= '0;
      code_buf <= '0;
      data_out <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      code_buf <= buf_next;
      if (load) data_out <= frame_next;
    end
  end

`ifdef DECODER_CORE_P_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_cnt <= '0;
    else if (consume) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
